// File: rtl/character_motion_ctrl_pkg.sv
// Shared types and helpers for the frame-buffer game character blocks.
package fb_game_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef enum logic [3:0] {
    DIR_LU    = 4'd0,
    DIR_UP    = 4'd1,
    DIR_RU    = 4'd2,
    DIR_LEFT  = 4'd3,
    DIR_STILL = 4'd4,
    DIR_RIGHT = 4'd5,
    DIR_LD    = 4'd6,
    DIR_DOWN  = 4'd7,
    DIR_RD    = 4'd8
  } dir_t;

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_MOVE  = 2'd1,
    ST_CLAMP = 2'd2
  } state_t;

  // dx, dy are each in {-1, 0, +1}
  function automatic dir_t dir_code(input logic signed [1:0] dx, input logic signed [1:0] dy);
    int v;
    v = (int'(dy) + 1) * 3 + int'(dx) + 1;
    return dir_t'(v[3:0]);
  endfunction

endpackage

// File: rtl/character_motion_ctrl_if.sv
// Key, pixel-position and sprite-output bundle between the video pipeline and the motion stage.
interface character_motion_ctrl_if;
  logic        frame_clk;
  logic        key_left;
  logic        key_right;
  logic        key_up;
  logic        key_down;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        is_char;
  logic [3:0]  char_dir;
  logic [11:0] char_addr;
  logic [9:0]  PosX;
  logic [9:0]  PosY;

  modport master (
    output frame_clk, key_left, key_right, key_up, key_down, DrawX, DrawY,
    input  is_char, char_dir, char_addr, PosX, PosY
  );

  modport slave (
    input  frame_clk, key_left, key_right, key_up, key_down, DrawX, DrawY,
    output is_char, char_dir, char_addr, PosX, PosY
  );
endinterface

// File: rtl/character_motion_ctrl_sprite_window.sv
// Combinational sprite box test and ROM address for the current pixel.
module sprite_window #(
  parameter int SPRITE_W = 32,
  parameter int SPRITE_H = 48
) (
  input  logic [9:0]  i_pos_x,
  input  logic [9:0]  i_pos_y,
  input  logic [9:0]  i_draw_x,
  input  logic [9:0]  i_draw_y,
  output logic        o_hit,
  output logic [11:0] o_addr
);
  logic [10:0] w_x_end;
  logic [10:0] w_y_end;
  logic [9:0]  w_rel_x;
  logic [9:0]  w_rel_y;

  // 11-bit ends so a sprite touching the right/bottom edge does not wrap
  assign w_x_end = {1'b0, i_pos_x} + 11'(SPRITE_W);
  assign w_y_end = {1'b0, i_pos_y} + 11'(SPRITE_H);

  assign o_hit = (i_draw_x >= i_pos_x) && ({1'b0, i_draw_x} < w_x_end) &&
                 (i_draw_y >= i_pos_y) && ({1'b0, i_draw_y} < w_y_end);

  assign w_rel_x = i_draw_x - i_pos_x;
  assign w_rel_y = i_draw_y - i_pos_y;
  assign o_addr  = o_hit ? (12'(w_rel_y) * 12'(SPRITE_W) + 12'(w_rel_x)) : 12'd0;
endmodule

// File: rtl/character_motion_ctrl.sv
// Per-frame character motion and per-pixel sprite addressing.
// Build option: define CHAR_GRAVITY_EN for jump/gravity vertical motion.
//
// state    | meaning
// ST_WAIT  | idle until a frame tick
// ST_MOVE  | decode keys, form unclamped next position
// ST_CLAMP | saturate to screen, commit Pos and char_dir
module character_motion_ctrl
  import fb_game_pkg::*;
#(
  parameter int SPRITE_W = 32,
  parameter int SPRITE_H = 48,
  parameter int STEP     = 2,
  parameter int X_INIT   = 64,
  parameter int Y_INIT   = 400,
  parameter int X_MAX    = SCREEN_W - 1,
  parameter int Y_MAX    = SCREEN_H - 1,
  parameter int JUMP_V   = 12
) (
  input logic Clk,
  input logic Reset_n,
  character_motion_ctrl_if.slave bus
);
  localparam logic signed [10:0] X_HI = 11'(X_MAX + 1 - SPRITE_W);
  localparam logic signed [10:0] Y_HI = 11'(Y_MAX + 1 - SPRITE_H);

  logic [1:0]         r_fc_sync;
  logic               w_tick;
  state_t             r_state;
  logic signed [10:0] r_next_x;
  logic signed [10:0] r_next_y;
  logic signed [1:0]  r_dx;
  logic [9:0]         r_pos_x;
  logic [9:0]         r_pos_y;
  dir_t               r_dir;
  logic               r_is_char;
  logic [11:0]        r_char_addr;
  logic signed [1:0]  w_dx;
  logic signed [1:0]  w_dy;
  logic signed [10:0] w_mv_x;
  logic signed [10:0] w_pos_x_s;
  logic signed [10:0] w_pos_y_s;
  logic               w_hit;
  logic [11:0]        w_addr;

  assign w_tick    = r_fc_sync[0] & ~r_fc_sync[1];
  assign w_pos_x_s = $signed({1'b0, r_pos_x});
  assign w_pos_y_s = $signed({1'b0, r_pos_y});

  assign w_dx = (bus.key_right && !bus.key_left) ? 2'sd1 :
                (bus.key_left && !bus.key_right) ? -2'sd1 : 2'sd0;
  assign w_dy = (bus.key_down && !bus.key_up) ? 2'sd1 :
                (bus.key_up && !bus.key_down) ? -2'sd1 : 2'sd0;
  assign w_mv_x = (w_dx == 2'sd1) ? 11'(STEP) : (w_dx == -2'sd1) ? -11'(STEP) : 11'sd0;

`ifdef CHAR_GRAVITY_EN
  logic signed [7:0] r_vel;
  logic signed [7:0] r_vel_nxt;
  logic signed [7:0] w_v;
  logic signed [7:0] w_vel_fin;
  logic              w_land;
  logic signed [1:0] w_vsign;

  // a jump can only start from the floor; otherwise keep the current velocity
  assign w_v       = (bus.key_up && (w_pos_y_s == Y_HI)) ? -8'(JUMP_V) : r_vel;
  assign w_land    = (r_next_y >= Y_HI);
  assign w_vel_fin = w_land ? 8'sd0 : r_vel_nxt;
  assign w_vsign   = (w_vel_fin > 8'sd0) ? 2'sd1 : (w_vel_fin < 8'sd0) ? -2'sd1 : 2'sd0;
`else
  logic signed [1:0]  r_dy;
  logic signed [10:0] w_mv_y;

  assign w_mv_y = (w_dy == 2'sd1) ? 11'(STEP) : (w_dy == -2'sd1) ? -11'(STEP) : 11'sd0;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_fc_sync <= '0;
      r_state   <= ST_WAIT;
      r_next_x  <= '0;
      r_next_y  <= '0;
      r_dx      <= '0;
      r_pos_x   <= 10'(X_INIT);
      r_pos_y   <= 10'(Y_INIT);
      r_dir     <= DIR_STILL;
`ifdef CHAR_GRAVITY_EN
      r_vel     <= '0;
      r_vel_nxt <= '0;
`else
      r_dy      <= '0;
`endif
    end else begin
      r_fc_sync <= {r_fc_sync[0], bus.frame_clk};
      case (r_state)
        ST_WAIT: if (w_tick) r_state <= ST_MOVE;
        ST_MOVE: begin
          r_dx     <= w_dx;
          r_next_x <= w_pos_x_s + w_mv_x;
`ifdef CHAR_GRAVITY_EN
          r_next_y  <= w_pos_y_s + 11'(w_v);
          r_vel_nxt <= (w_v >= $signed(8'(JUMP_V))) ? $signed(8'(JUMP_V)) : w_v + 8'sd1;
`else
          r_dy     <= w_dy;
          r_next_y <= w_pos_y_s + w_mv_y;
`endif
          r_state  <= ST_CLAMP;
        end
        ST_CLAMP: begin
          if (r_next_x < 11'sd0)     r_pos_x <= '0;
          else if (r_next_x > X_HI)  r_pos_x <= X_HI[9:0];
          else                       r_pos_x <= r_next_x[9:0];
`ifdef CHAR_GRAVITY_EN
          if (w_land)                r_pos_y <= Y_HI[9:0];
          else if (r_next_y < 11'sd0) r_pos_y <= '0;
          else                       r_pos_y <= r_next_y[9:0];
          r_vel <= w_vel_fin;
          r_dir <= dir_code(r_dx, w_vsign);
`else
          if (r_next_y < 11'sd0)     r_pos_y <= '0;
          else if (r_next_y > Y_HI)  r_pos_y <= Y_HI[9:0];
          else                       r_pos_y <= r_next_y[9:0];
          r_dir <= dir_code(r_dx, r_dy);
`endif
          r_state <= ST_WAIT;
        end
        default: r_state <= ST_WAIT;
      endcase
    end
  end

  sprite_window #(.SPRITE_W(SPRITE_W), .SPRITE_H(SPRITE_H)) u_window (
    .i_pos_x  (r_pos_x),
    .i_pos_y  (r_pos_y),
    .i_draw_x (bus.DrawX),
    .i_draw_y (bus.DrawY),
    .o_hit    (w_hit),
    .o_addr   (w_addr)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_is_char   <= 1'b0;
      r_char_addr <= '0;
    end else begin
      r_is_char   <= w_hit;
      r_char_addr <= w_addr;
    end
  end

  assign bus.is_char   = r_is_char;
  assign bus.char_addr = r_char_addr;
  assign bus.char_dir  = r_dir;
  assign bus.PosX      = r_pos_x;
  assign bus.PosY      = r_pos_y;
endmodule

// File: tb/tb_character_motion_ctrl.sv
// Bench for character_motion_ctrl: directed edge cases plus random keys/pixels against a rule model.
module tb_character_motion_ctrl;
  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   mx, my, mdir, mvel;

  localparam int XLIM = 608;
  localparam int YLIM = 432;

  character_motion_ctrl_if bus();
  character_motion_ctrl dut (.Clk(Clk), .Reset_n(Reset_n), .bus(bus.slave));

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  task automatic model_reset();
    mx = 64; my = 400; mdir = 4; mvel = 0;
  endtask

  // one video frame; model follows the motion rules directly
  task automatic frame(input bit l, input bit r, input bit u, input bit d);
    int dx, dy;
    @(negedge Clk);
    bus.key_left = l; bus.key_right = r; bus.key_up = u; bus.key_down = d;
    bus.frame_clk = 1'b1;
    repeat (6) @(negedge Clk);
    bus.frame_clk = 1'b0;
    repeat (2) @(negedge Clk);
    dx = int'(r) - int'(l);
    mx = clampi(mx + dx * 2, 0, XLIM);
`ifdef CHAR_GRAVITY_EN
    if (u && my == YLIM) mvel = -12;
    my = my + mvel;
    mvel = (mvel + 1 > 12) ? 12 : mvel + 1;
    if (my >= YLIM) begin my = YLIM; mvel = 0; end
    else if (my < 0) my = 0;
    dy = (mvel > 0) ? 1 : (mvel < 0) ? -1 : 0;
`else
    dy = int'(d) - int'(u);
    my = clampi(my + dy * 2, 0, YLIM);
`endif
    mdir = (dy + 1) * 3 + dx + 1;
    check("frame_posx", 32'(bus.PosX), 32'(mx));
    check("frame_posy", 32'(bus.PosY), 32'(my));
    check("frame_dir", 32'(bus.char_dir), 32'(mdir));
  endtask

  task automatic pixel(input int x, input int y);
    bit in;
    int ea;
    x = x & 1023; y = y & 1023;
    @(negedge Clk);
    bus.DrawX = 10'(x); bus.DrawY = 10'(y);
    @(negedge Clk);
    in = (x >= mx) && (x < mx + 32) && (y >= my) && (y < my + 48);
    ea = in ? (y - my) * 32 + (x - mx) : 0;
    check("pix_is_char", 32'(bus.is_char), 32'(in));
    check("pix_addr", 32'(bus.char_addr), 32'(ea));
  endtask

  initial begin
    bus.frame_clk = 0; bus.key_left = 0; bus.key_right = 0; bus.key_up = 0; bus.key_down = 0;
    bus.DrawX = 0; bus.DrawY = 0;
    model_reset();
    repeat (2) @(negedge Clk);
    check("rst_posx", 32'(bus.PosX), 32'd64);
    check("rst_posy", 32'(bus.PosY), 32'd400);
    check("rst_dir", 32'(bus.char_dir), 32'd4);
    check("rst_is_char", 32'(bus.is_char), 32'd0);
    check("rst_addr", 32'(bus.char_addr), 32'd0);
    Reset_n = 1'b1;

    repeat (3) frame(0, 1, 0, 0);
    check("right3_posx", 32'(bus.PosX), 32'd70);
`ifndef CHAR_GRAVITY_EN
    check("right3_dir", 32'(bus.char_dir), 32'd5);
`endif
    frame(1, 1, 0, 0);
    check("lr_posx", 32'(bus.PosX), 32'd70);
`ifndef CHAR_GRAVITY_EN
    check("lr_dir", 32'(bus.char_dir), 32'd4);
    frame(1, 0, 1, 0);
    check("ul_posy", 32'(bus.PosY), 32'd398);
    check("ul_posx", 32'(bus.PosX), 32'd68);
    check("ul_dir", 32'(bus.char_dir), 32'd0);
`endif

    // sprite box edges at the current position
    pixel(mx + 31, my + 47);
    check("corner_addr", 32'(bus.char_addr), 32'd1535);
    pixel(mx + 32, my + 47);
    pixel(mx, my);
    pixel(mx - 1, my);
    pixel(mx, my + 48);
    pixel(mx + 5, my - 1);

    // right wall, left wall, floor, ceiling
    for (int i = 0; i < 280; i++) frame(0, 1, 0, 0);
    check("wall_r_posx", 32'(bus.PosX), 32'd608);
    pixel(639, my);
    for (int i = 0; i < 310; i++) frame(1, 0, 0, 0);
    check("wall_l_posx", 32'(bus.PosX), 32'd0);
    pixel(0, my + 10);
`ifndef CHAR_GRAVITY_EN
    check("wall_l_dir", 32'(bus.char_dir), 32'd3);
    for (int i = 0; i < 30; i++) frame(0, 0, 0, 1);
    check("floor_posy", 32'(bus.PosY), 32'd432);
    check("floor_dir", 32'(bus.char_dir), 32'd7);
    for (int i = 0; i < 220; i++) frame(0, 0, 1, 0);
    check("ceil_posy", 32'(bus.PosY), 32'd0);
    check("ceil_dir", 32'(bus.char_dir), 32'd1);
`endif

    for (int i = 0; i < 200; i++) begin
      automatic logic [3:0] k = 4'($urandom);
      frame(k[0], k[1], k[2], k[3]);
      repeat (2) pixel(mx + int'($urandom_range(0, 40)) - 4, my + int'($urandom_range(0, 56)) - 4);
    end

    // reset mid-frame with the sprite under the beam and a tick pending
    pixel(mx + 3, my + 3);
    @(negedge Clk);
    bus.frame_clk = 1'b1;
    @(posedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    model_reset();
    check("midrst_posx", 32'(bus.PosX), 32'd64);
    check("midrst_posy", 32'(bus.PosY), 32'd400);
    check("midrst_dir", 32'(bus.char_dir), 32'd4);
    check("midrst_is_char", 32'(bus.is_char), 32'd0);
    bus.frame_clk = 1'b0;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    frame(0, 0, 0, 0);

`ifdef CHAR_GRAVITY_EN
    for (int i = 0; i < 40 && my != YLIM; i++) frame(0, 0, 0, 0);
    check("grav_grounded", 32'(bus.PosY), 32'd432);
    frame(0, 0, 1, 0);
    check("jump_first", 32'(bus.PosY), 32'd420);
    check("jump_dir", 32'(bus.char_dir), 32'd1);
    for (int i = 0; i < 24; i++) frame(0, 0, 0, 0);
    check("jump_land_posy", 32'(bus.PosY), 32'd432);
    check("jump_land_dir", 32'(bus.char_dir), 32'd4);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
